frac_clk_gen: RTL and testbench

Synthesizable fractional clock generator driven from the 100 MHz reference clock. It derives lower-rate clocks such as 16 MHz and 8 MHz through a phase accumulator, so non-integer ratios (100/16 = 6.25) need no behavioural `#31.25`-style delays. Its outputs are registered clock-like signals and single-cycle tick enables, which feed the counters and sequential blocks downstream. The increment is reprogrammable at runtime through a valid/ready handshake, and a new value takes effect only at a phase wrap.

---
 rtl/frac_clk_gen_if.sv | 27 ++
 rtl/frac_clk_gen.sv | 145 ++++++++++++++
 tb/tb_frac_clk_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/frac_clk_gen_if.sv
// Configuration/status bundle for frac_clk_gen.
// clk_half is present only when CLK_HALF_EN is defined.
interface frac_clk_gen_if #(
    parameter int ACC_W = 16,
    parameter int PER_W = 8
);
    logic             en;
    logic [ACC_W-1:0] cfg_inc;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic [PER_W-1:0] period_len;
`ifdef CLK_HALF_EN
    logic             clk_half;

    modport master (output en, cfg_inc, cfg_valid,
                    input  cfg_ready, clk_out, tick, period_len, clk_half);
    modport slave  (input  en, cfg_inc, cfg_valid,
                    output cfg_ready, clk_out, tick, period_len, clk_half);
`else
    modport master (output en, cfg_inc, cfg_valid,
                    input  cfg_ready, clk_out, tick, period_len);
    modport slave  (input  en, cfg_inc, cfg_valid,
                    output cfg_ready, clk_out, tick, period_len);
`endif
endinterface

// File: rtl/frac_clk_gen.sv
// Phase-accumulator fractional clock generator with wrap-synchronised increment reload.
// Optional divide-by-two output enabled by defining CLK_HALF_EN.
module frac_clk_gen #(
    parameter int          ACC_W     = 16,
    parameter int unsigned RESET_INC = 10486,
    parameter int          PER_W     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    frac_clk_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

    localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(RESET_INC);
    localparam logic [ACC_W-1:0] INC_MAX  = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [PER_W-1:0] PCNT_MAX = '1;

    state_t           state_reg, state_next;
    logic [ACC_W-1:0] acc_reg, acc_next;
    logic [ACC_W-1:0] inc_reg, inc_next;
    logic [ACC_W-1:0] pend_reg, pend_next;
    logic [PER_W-1:0] pcnt_reg, pcnt_next;
    logic [PER_W-1:0] plen_reg, plen_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;
`ifdef CLK_HALF_EN
    logic             half_reg, half_next;
`endif

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             cfg_ready;
    logic             hs;
    logic [ACC_W-1:0] cfg_clamped;
    logic [PER_W-1:0] pcnt_inc;

    assign sum         = {1'b0, acc_reg} + {1'b0, inc_reg};
    assign carry       = sum[ACC_W];
    assign cfg_ready   = (state_reg != PEND);
    assign hs          = bus.cfg_valid && cfg_ready;
    // Increments at or above half scale would alias, so clamp to f_clk/2.
    assign cfg_clamped = bus.cfg_inc[ACC_W-1] ? INC_MAX : bus.cfg_inc;
    assign pcnt_inc    = (pcnt_reg == PCNT_MAX) ? pcnt_reg : pcnt_reg + 1'b1;

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        inc_next     = inc_reg;
        pend_next    = pend_reg;
        pcnt_next    = pcnt_reg;
        plen_next    = plen_reg;
        clk_out_next = clk_out_reg;
        tick_next    = 1'b0;
`ifdef CLK_HALF_EN
        half_next    = half_reg;
`endif
        case (state_reg)
            IDLE: begin
                acc_next     = '0;
                clk_out_next = 1'b0;
                pcnt_next    = '0;
`ifdef CLK_HALF_EN
                half_next    = 1'b0;
`endif
                if (hs)
                    inc_next = cfg_clamped;
                if (bus.en)
                    state_next = RUN;
            end
            RUN, PEND: begin
                if (!bus.en) begin
                    state_next   = IDLE;
                    acc_next     = '0;
                    clk_out_next = 1'b0;
                    pcnt_next    = '0;
`ifdef CLK_HALF_EN
                    half_next    = 1'b0;
`endif
                    // A value accepted on the stopping edge is not lost.
                    if (state_reg == PEND)
                        inc_next = pend_reg;
                    else if (hs)
                        inc_next = cfg_clamped;
                end else begin
                    acc_next     = sum[ACC_W-1:0];
                    clk_out_next = acc_reg[ACC_W-1];
                    tick_next    = carry;
                    if (carry) begin
                        plen_next = pcnt_inc;
                        pcnt_next = '0;
`ifdef CLK_HALF_EN
                        half_next = ~half_reg;
`endif
                    end else begin
                        pcnt_next = pcnt_inc;
                    end
                    if (state_reg == RUN && hs) begin
                        pend_next  = cfg_clamped;
                        state_next = PEND;
                    end else if (state_reg == PEND && carry) begin
                        inc_next   = pend_reg;
                        state_next = RUN;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            inc_reg     <= INC_RST;
            pend_reg    <= '0;
            pcnt_reg    <= '0;
            plen_reg    <= '0;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
`ifdef CLK_HALF_EN
            half_reg    <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            inc_reg     <= inc_next;
            pend_reg    <= pend_next;
            pcnt_reg    <= pcnt_next;
            plen_reg    <= plen_next;
            clk_out_reg <= clk_out_next;
            tick_reg    <= tick_next;
`ifdef CLK_HALF_EN
            half_reg    <= half_next;
`endif
        end
    end

    assign bus.cfg_ready  = cfg_ready;
    assign bus.clk_out    = clk_out_reg;
    assign bus.tick       = tick_reg;
    assign bus.period_len = plen_reg;
`ifdef CLK_HALF_EN
    assign bus.clk_half   = half_reg;
`endif
endmodule

// File: tb/tb_frac_clk_gen.sv
// Directed self-checking bench for frac_clk_gen (cycle k = k-th edge after entering RUN).
module tb_frac_clk_gen;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frac_clk_gen_if #(.ACC_W(16), .PER_W(8)) bus ();

    frac_clk_gen #(.ACC_W(16), .RESET_INC(10486), .PER_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n    = -1;
        for (int i = 1; i <= limit; i++) begin
            if (!seen) begin
                step();
                if (bus.tick) begin
                    n    = i;
                    seen = 1'b1;
                end
            end
        end
    endtask

    task automatic cfg_write_idle(input logic [15:0] val);
        bus.cfg_inc   = val;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        $display("txn: load inc 0x%04h in IDLE", val);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, ntick, first, last, bad;
        bus.en        = 1'b0;
        bus.cfg_valid = 1'b0;
        bus.cfg_inc   = '0;

        // Asynchronous reset before the first clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clk_out", bus.clk_out, 0);
        chk("rst_tick", bus.tick, 0);
        chk("rst_period_len", bus.period_len, 0);
        chk("rst_cfg_ready", bus.cfg_ready, 1);
`ifdef CLK_HALF_EN
        chk("rst_clk_half", bus.clk_half, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Reset increment 10486: 160 ticks in 1000 cycles, spacing 6/7
        bus.en = 1'b1;
        step();
        ntick = 0; first = 0; last = 0; bad = 0;
        for (int k = 1; k <= 1000; k++) begin
            step();
            if (bus.tick) begin
                ntick++;
                if (first == 0) first = k;
                else if ((k - last) != 6 && (k - last) != 7) bad++;
                if (bus.period_len != 6 && bus.period_len != 7) bad++;
                last = k;
            end
        end
        $display("txn: 1000 cycles at reset inc, %0d ticks", ntick);
        chk("t1_tick_count", ntick, 160);
        chk("t1_first_tick", first, 7);
        chk("t1_spacing_bad", bad, 0);

        // Stop, then 16384: period 4, clk_out 2 high / 2 low
        bus.en = 1'b0;
        step();
        chk("t2_stop_clk_out", bus.clk_out, 0);
        chk("t2_stop_tick", bus.tick, 0);
        cfg_write_idle(16'd16384);
        bus.en = 1'b1;
        step();
        wait_tick(50, n);
        chk("t2_first_tick", n, 4);
        for (int k = 5; k <= 12; k++) begin
            step();
            chk("t2_tick", bus.tick, ((k % 4) == 0) ? 1 : 0);
            chk("t2_clk_out", bus.clk_out, (((k - 1) % 4) >= 2) ? 1 : 0);
`ifdef CLK_HALF_EN
            chk("t2_clk_half", bus.clk_half, (k / 4) % 2);
`endif
        end
        chk("t2_period_len", bus.period_len, 4);

        // 0xFFFF clamps to 0x8000: clk_out toggles every cycle
        bus.en = 1'b0;
        step();
        cfg_write_idle(16'hFFFF);
        bus.en = 1'b1;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t3_tick", bus.tick, ((k % 2) == 0) ? 1 : 0);
            chk("t3_clk_out", bus.clk_out, ((k % 2) == 0) ? 1 : 0);
        end
        chk("t3_period_len", bus.period_len, 2);

        // Runtime change 10486 -> 16384 takes effect at the wrap
        bus.en = 1'b0;
        step();
        cfg_write_idle(16'd10486);
        bus.en = 1'b1;
        step();
        for (int k = 1; k <= 3; k++) step();
        bus.cfg_inc   = 16'd16384;
        bus.cfg_valid = 1'b1;
        step();
        $display("txn: handshake 16384 in RUN at cycle 4");
        chk("t4_ready_drop", bus.cfg_ready, 0);
        bus.cfg_inc = 16'h8000;
        step();
        chk("t4_no_early_tick", bus.tick, 0);
        step();
        chk("t4_pend_ready", bus.cfg_ready, 0);
        bus.cfg_valid = 1'b0;
        step();
        chk("t4_old_spacing_tick", bus.tick, 1);
        chk("t4_ready_back", bus.cfg_ready, 1);
        for (int k = 8; k <= 15; k++) begin
            step();
            chk("t4_new_tick", bus.tick, (k == 11 || k == 15) ? 1 : 0);
        end
        chk("t4_period_len", bus.period_len, 4);

        // Async reset while PEND discards the pending value
        bus.cfg_inc   = 16'h8000;
        bus.cfg_valid = 1'b1;
        step();
        bus.cfg_valid = 1'b0;
        step();
        step();
        chk("t5_pend_ready", bus.cfg_ready, 0);
        chk("t5_pre_clk_out", bus.clk_out, 1);
        #2 rst_n = 1'b0;
        #1;
        $display("txn: async reset asserted in PEND");
        chk("t5_rst_cfg_ready", bus.cfg_ready, 1);
        chk("t5_rst_clk_out", bus.clk_out, 0);
        chk("t5_rst_tick", bus.tick, 0);
        chk("t5_rst_period_len", bus.period_len, 0);
`ifdef CLK_HALF_EN
        chk("t5_rst_clk_half", bus.clk_half, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        step();
        wait_tick(50, n);
        chk("t5_first_tick", n, 7);
        wait_tick(50, n);
        chk("t5_second_spacing", n, 6);
        chk("t5_period_len", bus.period_len, 6);

        // en low mid-period clears phase and period counter
        for (int k = 14; k <= 17; k++) step();
        chk("t6_pre_clk_out", bus.clk_out, 1);
        bus.en = 1'b0;
        step();
        $display("txn: en dropped mid-period");
        chk("t6_stop_clk_out", bus.clk_out, 0);
        chk("t6_stop_tick", bus.tick, 0);
        chk("t6_hold_period_len", bus.period_len, 6);
        step();
        bus.en = 1'b1;
        step();
        wait_tick(50, n);
        chk("t6_restart_first_tick", n, 7);
        chk("t6_restart_period_len", bus.period_len, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
